// File: rtl/rgb_gray_pkg.sv
// Shared types, default gains and width helpers
// for the streaming RGB-to-gray converter.
package rgb_gray_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  // BT.601 luma weights in Q0.8, channel 0 (R) in the LSBs
  localparam logic [23:0] BT601_GAINS = {8'd29, 8'd150, 8'd77};

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  function automatic int iw_f(input int ch);
    return (clog2_f(ch) < 1) ? 1 : clog2_f(ch);
  endfunction

  function automatic int aw_f(input int dw, input int gw, input int ch);
    return dw + gw + clog2_f(ch) + 1;
  endfunction

endpackage

// File: rtl/rgb_to_gray_stream_mac.sv
// Single multiply-accumulate lane shared by all
// channels of a pixel.
module gray_mac
  import rgb_gray_pkg::*;
#(
  parameter int DW = 8,
  parameter int GW = 8,
  parameter int AW = aw_f(8, 8, 3)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] pix_i,
  input  logic [GW-1:0] gain_i,
  output logic [AW-1:0] acc_o
);

  logic [DW+GW-1:0] prod;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_d;

  assign prod = {{GW{1'b0}}, pix_i} * {{DW{1'b0}}, gain_i};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/rgb_to_gray_stream.sv
// Streaming RGB-to-gray converter: one shared MAC
// over CH channels, then round and saturate.
module rgb_to_gray_stream
  import rgb_gray_pkg::*;
#(
  parameter int CH = 3,
  parameter int DW = 8,
  parameter int GW = 8,
  parameter logic [CH*GW-1:0] GAIN_INIT = (CH*GW)'(BT601_GAINS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*DW-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  input  logic                  cfg_we,
  input  logic [iw_f(CH)-1:0]   cfg_idx,
  input  logic [GW-1:0]         cfg_gain,
  output logic                  busy
);

  localparam int IW = iw_f(CH);
  localparam int AW = aw_f(DW, GW, CH);
  localparam int RW = AW - GW;
  localparam logic [AW-1:0] HALF = AW'(1) << (GW - 1);
  localparam logic [IW-1:0] LAST = IW'(CH - 1);

  state_e                  state_q;
  logic [CH-1:0][DW-1:0]   pix_q;
  logic [CH-1:0][GW-1:0]   gain_q;
  logic [IW-1:0]           idx_q;
  logic [DW-1:0]           out_data_q;
  logic                    out_valid_q;

  logic                    accept;
  logic                    mac_en;
  logic [AW-1:0]           acc;
  logic [AW-1:0]           rnd;
  logic [RW-1:0]           res;
  logic [DW-1:0]           sat;

  assign accept = (state_q == S_IDLE) && in_valid;
  assign mac_en = (state_q == S_MAC);

  gray_mac #(
    .DW(DW),
    .GW(GW),
    .AW(AW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (mac_en),
    .pix_i (pix_q[idx_q]),
    .gain_i(gain_q[idx_q]),
    .acc_o (acc)
  );

  // Headroom in AW guarantees the rounding add never wraps
  assign rnd = acc + HALF;
  assign res = rnd[AW-1:GW];
  assign sat = (|res[RW-1:DW]) ? {DW{1'b1}} : res[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      gain_q      <= GAIN_INIT;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cfg_we && (32'(cfg_idx) < CH)) begin
            gain_q[cfg_idx] <= cfg_gain;
          end
          if (in_valid) begin
            pix_q   <= in_data;
            idx_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          idx_q <= idx_q + IW'(1);
          if (idx_q == LAST) begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          out_data_q  <= sat;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Directed bench for rgb_to_gray_stream with
// hand-computed BT.601 results.
module tb_rgb_to_gray_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [7:0]  cfg_gain = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  rgb_to_gray_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_gain (cfg_gain),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
    @(negedge clk);
    in_data  = {b, g, r};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns the cycle (accept edge = 0) in which out_valid is seen, or -1
  task automatic wait_result(output int lat);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 40);
    lat = out_valid ? n + 1 : -1;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic set_gain(input logic [1:0] idx, input logic [7:0] g);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_gain = g;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    total++;
    if (out_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_out_data got=%0d exp=0", out_data);
    end
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_busy got=%b%b exp=10", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int lat;
    send_pixel(8'd100, 8'd50, 8'd200);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy got=%b%b exp=10", busy, in_ready);
    end
    wait_result(lat);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=5", lat);
    end
    total++;
    if (out_data !== 8'd82) begin
      bad++;
      $display("FAIL basic_data got=%0d exp=82", out_data);
    end
    consume();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_release got=%b%b exp=01", out_valid, in_ready);
    end
  endtask

  task automatic test_white();
    int lat;
    send_pixel(8'd255, 8'd255, 8'd255);
    wait_result(lat);
    total++;
    if (lat !== 5 || out_data !== 8'd255) begin
      bad++;
      $display("FAIL white got=%0d/%0d exp=5/255", lat, out_data);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    send_pixel(8'd100, 8'd50, 8'd200);
    wait_result(lat);
    in_data  = {8'd255, 8'd255, 8'd255};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'd82 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d got=%b/%0d/%b exp=1/82/0",
                 i, out_valid, out_data, in_ready);
      end
    end
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_release got=%b%b%b exp=010",
               out_valid, in_ready, busy);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_no_second got=%b%b exp=00", out_valid, busy);
    end
  endtask

  task automatic test_saturate();
    int lat;
    set_gain(2'd0, 8'd255);
    set_gain(2'd1, 8'd255);
    set_gain(2'd2, 8'd255);
    send_pixel(8'd255, 8'd255, 8'd255);
    wait_result(lat);
    total++;
    if (out_data !== 8'd255) begin
      bad++;
      $display("FAIL saturate got=%0d exp=255", out_data);
    end
    consume();
    send_pixel(8'd1, 8'd1, 8'd1);
    wait_result(lat);
    total++;
    if (out_data !== 8'd3) begin
      bad++;
      $display("FAIL gains_255_small got=%0d exp=3", out_data);
    end
    consume();
  endtask

  task automatic test_rst_abort();
    int lat;
    int seen;
    send_pixel(8'd255, 8'd0, 8'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got=%b%b%b exp=100",
               in_ready, busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_result got=%0d exp=0", seen);
    end
    send_pixel(8'd255, 8'd0, 8'd0);
    wait_result(lat);
    total++;
    if (lat !== 5 || out_data !== 8'd77) begin
      bad++;
      $display("FAIL abort_gain_revert got=%0d/%0d exp=5/77", lat, out_data);
    end
    consume();
  endtask

  task automatic test_cfg();
    int lat;
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_idx  = 2'd0;
    cfg_gain = 8'd0;
    in_data  = {8'd0, 8'd0, 8'd255};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_idx  = 2'd0;
    cfg_gain = 8'd200;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    wait_result(lat);
    total++;
    if (out_data !== 8'd0) begin
      bad++;
      $display("FAIL cfg_same_cycle got=%0d exp=0", out_data);
    end
    consume();
    set_gain(2'd3, 8'd0);
    send_pixel(8'd255, 8'd0, 8'd0);
    wait_result(lat);
    total++;
    if (out_data !== 8'd0) begin
      bad++;
      $display("FAIL cfg_mac_write_ignored got=%0d exp=0", out_data);
    end
    consume();
    send_pixel(8'd0, 8'd255, 8'd255);
    wait_result(lat);
    total++;
    if (lat !== 5 || out_data !== 8'd178) begin
      bad++;
      $display("FAIL cfg_idx3_ignored got=%0d/%0d exp=5/178", lat, out_data);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_white();
    test_backpressure();
    test_saturate();
    test_rst_abort();
    test_cfg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb_to_gray_stream.md
# rgb_to_gray_stream

Parametrised, handshake-driven successor to the RGB-to-grayscale datapath/controller pair. Converts one CH-channel pixel to a DW-bit luma value by time-multiplexing a single multiplier-accumulator over the channels with run-time programmable gains, then applies rounding and saturation. Sits between the pixel source and the gray-frame writer with valid/ready handshakes on both sides.

## Interface
- CH, 3, number of channels per pixel (1..8)
- DW, 8, bits per channel and per output sample
- GW, 8, gain width; gains are unsigned Q0.GW (gain/2^GW)
- GAIN_INIT, {8'd29, 8'd150, 8'd77}, packed CH*GW reset gains, channel 0 in LSBs (BT.601)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pixel present on in_data
- in_ready  out  1  block can accept a pixel (combinational from state)
- in_data  in  CH*DW  pixel, channel i at bits [i*DW +: DW]
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream accepts result
- out_data  out  DW  rounded, saturated gray value
- cfg_we  in  1  gain write strobe
- cfg_idx  in  IW  channel index, IW = max(1, clog2(CH))
- cfg_gain  in  GW  new gain value
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, MAC, ROUND, OUT. Reset -> IDLE.
- IDLE: in_ready=1. On in_valid: latch in_data into pixel reg, acc<=0, idx<=0, -> MAC.
- MAC: acc <= acc + pix[idx]*gain[idx]; idx++; after idx==CH-1 -> ROUND. Exactly CH cycles.
- ROUND: res = (acc + 2^(GW-1)) >> GW; if res > 2^DW-1 then out_data <= 2^DW-1 else out_data <= res[DW-1:0]; -> OUT.
- OUT: out_valid=1, out_data stable; on out_ready -> IDLE. in_ready=0 here.
- Accumulator width AW = DW+GW+clog2(CH)+1; no intermediate overflow for any gain setting.
- Gain regs: write accepted only in IDLE; cfg_idx >= CH ignored; writes in MAC/ROUND/OUT ignored (no queueing).
- cfg write and pixel accept in the same IDLE cycle: gain updates at that edge and applies to that pixel.
- Reset values: state IDLE, out_valid 0, out_data 0, acc 0, idx 0, pixel reg 0, gains GAIN_INIT; in_ready 1 and busy 0 in the first cycle after reset.
- rst in any state aborts the pixel: next cycle IDLE, out_valid 0, no result emitted, gains revert to GAIN_INIT.

## Timing
- Accept edge = cycle 0. MAC cycles 1..CH, ROUND cycle CH+1, out_valid high from cycle CH+2 (5 for CH=3).
- Minimum pixel period CH+3 cycles (OUT handshake then one IDLE cycle); in_ready never high in OUT.
- out_valid, once high, stays high with constant out_data until out_valid&out_ready sampled; deasserts the following cycle.
- All outputs registered except in_ready and busy (decoded from the state register only, no input-to-output paths).

## Structure
- Shared package rgb_gray_pkg: state encoding localparams, BT.601 default gains (77,150,29), clog2 helper, IW/AW width derivation.
- One sub-module natural: gray_mac (registered acc with clear/enable, DW x GW multiplier, AW output); FSM, gain regs, round/saturate stay in the top.

## Test plan
- After reset, default gains, pixel (R,G,B)=(100,50,200) -> acc 21000, out_data=82, out_valid at cycle 5 after accept.
- Pixel (255,255,255), default gains -> acc 65280, out_data=255 (rounding does not exceed range).
- Write gains 255,255,255, pixel (255,255,255) -> acc 195075, out_data saturates to 255.
- out_ready held low 10 cycles after result -> out_valid/out_data stable, in_ready 0, second in_valid not accepted; out_ready high -> out_valid low next cycle, in_ready 1.
- rst pulsed in cycle 2 of MAC -> IDLE next cycle, out_valid never asserts, previously written gains revert to 77/150/29.
- cfg_we in IDLE with cfg_idx=0, cfg_gain=0, same-cycle pixel (255,0,0) -> out_data=0; cfg_we during MAC or with cfg_idx=3 -> gains unchanged.
